ch_stats_csr_responder: RTL

- Responder end of the per-channel MM CSR bus: the block a channel address decoder drives through its ADDR/WR_DATA/WR_EN/RD_EN outputs and samples through RD_DATA/RD_DATA_V.
- Holds a small register bank (ID, scratch, control, interrupt status/mask) and NUM_EVT saturating event counters.
- Returns read data with fixed, parameterised latency.
- Raises a maskable interrupt when a counter saturates.

---
 rtl/ch_stats_csr_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ch_stats_csr_responder.sv
// ch_stats_csr_responder
// Responder end of the per-channel MM CSR bus. Holds ID/scratch/control/
// interrupt registers and NUM_EVT saturating event counters. Read data comes
// back through a fixed RD_LAT-deep shift pipeline.
// Optional build macro: CH_CSR_SNAPSHOT_EN adds CTRL[62] SNAP and a shadow
// copy of every counter; counter reads then return the shadow copy.
//
// Word address map (only addr[9:0] decoded):
//   0x000 ID  0x001 SCRATCH  0x002 CTRL  0x003 INT_STATUS (W1C)
//   0x004 INT_MASK  0x010+i CNT[i]

module ch_stats_csr_responder #(
  parameter logic [63:0] BLOCK_ID = 64'h0000_0000_0000_0001,
  parameter int          NUM_EVT  = 8,
  parameter int          CNT_W    = 48,
  parameter int          RD_LAT   = 2,
  parameter int          RD_CLR   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [13:0]        iMM_ADDR,
  input  logic               iMM_WR_EN,
  input  logic               iMM_RD_EN,
  input  logic [63:0]        iMM_WR_DATA,
  output logic [63:0]        oMM_RD_DATA,
  output logic               oMM_RD_DATA_V,
  input  logic [NUM_EVT-1:0] iEVT,
  output logic               oIRQ
);

  localparam logic [9:0]       ADDR_ID      = 10'h000;
  localparam logic [9:0]       ADDR_SCRATCH = 10'h001;
  localparam logic [9:0]       ADDR_CTRL    = 10'h002;
  localparam logic [9:0]       ADDR_STAT    = 10'h003;
  localparam logic [9:0]       ADDR_MASK    = 10'h004;
  localparam logic [9:0]       CNT_BASE     = 10'h010;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [9:0]         addr;
  logic               unused_addr_hi;

  logic [63:0]        scratch;
  logic [NUM_EVT-1:0] ctrl_en;
  logic [NUM_EVT-1:0] int_status;
  logic [NUM_EVT-1:0] int_mask;
  logic [CNT_W-1:0]   cnt     [NUM_EVT];
  logic [CNT_W-1:0]   cnt_nxt [NUM_EVT];

  logic               wr_scratch, wr_ctrl, wr_stat, wr_mask, clr_all;
  logic [NUM_EVT-1:0] cnt_rd_hit;
  logic [NUM_EVT-1:0] sat_set;
  logic [NUM_EVT-1:0] st_nxt;
  logic [63:0]        rd_mux;

  logic [RD_LAT-1:0]  pipe_v;
  logic [63:0]        pipe_d [RD_LAT];

`ifdef CH_CSR_SNAPSHOT_EN
  logic               snap;
  logic [CNT_W-1:0]   shadow [NUM_EVT];
`endif

  // Block select lives upstream; the top address bits are deliberately dropped.
  assign addr           = iMM_ADDR[9:0];
  assign unused_addr_hi = ^iMM_ADDR[13:10];

  assign wr_scratch = iMM_WR_EN && (addr == ADDR_SCRATCH);
  assign wr_ctrl    = iMM_WR_EN && (addr == ADDR_CTRL);
  assign wr_stat    = iMM_WR_EN && (addr == ADDR_STAT);
  assign wr_mask    = iMM_WR_EN && (addr == ADDR_MASK);
  assign clr_all    = wr_ctrl && iMM_WR_DATA[63];
`ifdef CH_CSR_SNAPSHOT_EN
  assign snap       = wr_ctrl && iMM_WR_DATA[62];
`endif

  // Read mux: sees pre-write state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_mux = {32'hDEAD_BEEF, 22'b0, addr};
    case (addr)
      ADDR_ID:      rd_mux = BLOCK_ID;
      ADDR_SCRATCH: rd_mux = scratch;
      ADDR_CTRL:    rd_mux = 64'(ctrl_en);
      ADDR_STAT:    rd_mux = 64'(int_status);
      ADDR_MASK:    rd_mux = 64'(int_mask);
      default:      ;
    endcase
    for (int i = 0; i < NUM_EVT; i++) begin
      if (addr == CNT_BASE + 10'(i)) begin
`ifdef CH_CSR_SNAPSHOT_EN
        rd_mux = 64'(shadow[i]);
`else
        rd_mux = 64'(cnt[i]);
`endif
      end
    end
  end

  // Per-counter next value: CLR_ALL beats read-clear, read-clear keeps a same-cycle event.
  always_comb begin
    sat_set    = '0;
    cnt_rd_hit = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      cnt_nxt[i]    = cnt[i];
      cnt_rd_hit[i] = iMM_RD_EN && (addr == CNT_BASE + 10'(i));
      if (clr_all) begin
        cnt_nxt[i] = '0;
      end else if ((RD_CLR != 0) && cnt_rd_hit[i]) begin
        cnt_nxt[i] = (ctrl_en[i] && iEVT[i]) ? CNT_ONE : '0;
      end else if (ctrl_en[i] && iEVT[i] && (cnt[i] != CNT_MAX)) begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
        sat_set[i] = ((cnt[i] + CNT_ONE) == CNT_MAX);
      end
    end
    // Hardware set wins over a same-cycle W1C.
    st_nxt = (int_status & ~(wr_stat ? iMM_WR_DATA[NUM_EVT-1:0] : '0)) | sat_set;
  end

  // Register bank, counters and interrupt output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch    <= '0;
      ctrl_en    <= '0;
      int_status <= '0;
      int_mask   <= '0;
      oIRQ       <= 1'b0;
      for (int i = 0; i < NUM_EVT; i++) cnt[i] <= '0;
    end else begin
      if (wr_scratch) scratch  <= iMM_WR_DATA;
      if (wr_ctrl)    ctrl_en  <= iMM_WR_DATA[NUM_EVT-1:0];
      if (wr_mask)    int_mask <= iMM_WR_DATA[NUM_EVT-1:0];
      int_status <= st_nxt;
      oIRQ       <= |(int_status & ~int_mask);
      for (int i = 0; i < NUM_EVT; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef CH_CSR_SNAPSHOT_EN
  // Shadow copy of the live counters, taken on SNAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EVT; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_EVT; i++) shadow[i] <= cnt[i];
    end
  end
`endif

  // Read response pipeline; each data stage only loads with a valid, so the
  // output holds its last value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe_d[s] <= '0;
    end else begin
      pipe_v[0] <= iMM_RD_EN;
      if (iMM_RD_EN) pipe_d[0] <= rd_mux;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        if (pipe_v[s-1]) pipe_d[s] <= pipe_d[s-1];
      end
    end
  end

  assign oMM_RD_DATA   = pipe_d[RD_LAT-1];
  assign oMM_RD_DATA_V = pipe_v[RD_LAT-1];

endmodule
